result_packetizer: RTL and testbench

- Sits between the boundary Encoder and UART_Transmit.
- On each Encoder Done pulse, latches start_x, start_y, Area, Perimiter and Error.
- Serialises the latched result into a fixed-length byte frame, one byte at a time, using the UART T_EN/Transmit_Done handshake.
- Lets the host receive one complete shape measurement per frame.

---
 rtl/result_packetizer_pkg.sv | 28 ++
 rtl/result_packetizer_frame_byte_select.sv | 45 ++++
 rtl/result_packetizer.sv | 163 ++++++++++++++++
 tb/tb_result_packetizer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_packetizer_pkg.sv
// Shared constants for the result packetizer: FSM encodings, STATUS layout, frame length.
// The optional trailing checksum byte is enabled by RESULT_PACKETIZER_CHECKSUM_EN.
package result_packetizer_pkg;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSend   = 2'd1;
    localparam logic [1:0] StWait   = 2'd2;
    localparam logic [1:0] StFinish = 2'd3;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    localparam int unsigned ERR_BIT = 0;
    localparam int unsigned OVR_BIT = 1;

`ifdef RESULT_PACKETIZER_CHECKSUM_EN
    localparam int unsigned CHECKSUM_BYTES = 1;
`else
    localparam int unsigned CHECKSUM_BYTES = 0;
`endif

    // HEADER + STATUS + two coordinates + area + perimeter (+ checksum)
    function automatic int unsigned frame_len(input int unsigned coord_w,
                                              input int unsigned area_w,
                                              input int unsigned perim_w);
        return 2 + 2 * (coord_w / 8) + area_w / 8 + perim_w / 8 + CHECKSUM_BYTES;
    endfunction

endpackage

// File: rtl/result_packetizer_frame_byte_select.sv
// Combinational frame byte mux: byte index plus latched fields to the outgoing byte.
// The checksum slot exists only when RESULT_PACKETIZER_CHECKSUM_EN is defined.
module result_packetizer_frame_byte_select
    import result_packetizer_pkg::*;
#(
    parameter int unsigned COORD_W = 16,
    parameter int unsigned AREA_W  = 24,
    parameter int unsigned PERIM_W = 16,
    parameter int unsigned IDX_W   = 4,
    parameter logic [7:0]  HEADER  = HEADER_DEFAULT
) (
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [7:0]         status_i,
    input  logic [COORD_W-1:0] start_x_i,
    input  logic [COORD_W-1:0] start_y_i,
    input  logic [AREA_W-1:0]  area_i,
    input  logic [PERIM_W-1:0] perim_i,
`ifdef RESULT_PACKETIZER_CHECKSUM_EN
    input  logic [7:0]         checksum_i,
`endif
    output logic [7:0]         data_o
);

    localparam int unsigned BODY_W     = 8 + 2 * COORD_W + AREA_W + PERIM_W;
    localparam int unsigned BODY_BYTES = BODY_W / 8;

    logic [BODY_W-1:0] body;
    assign body = {status_i, start_x_i, start_y_i, area_i, perim_i};

    // Index 0 is the header; body bytes follow MSB first from index 1.
    always_comb begin
        data_o = HEADER;
        for (int i = 0; i < BODY_BYTES; i++) begin
            if (idx_i == IDX_W'(i + 1)) begin
                data_o = body[(BODY_BYTES - 1 - i) * 8 +: 8];
            end
        end
`ifdef RESULT_PACKETIZER_CHECKSUM_EN
        if (idx_i == IDX_W'(BODY_BYTES + 1)) begin
            data_o = checksum_i;
        end
`endif
    end

endmodule

// File: rtl/result_packetizer.sv
// Latches one Encoder result per Done pulse and streams it to the UART as a byte frame.
// Define RESULT_PACKETIZER_CHECKSUM_EN to append an XOR checksum of STATUS..Perimiter.
module result_packetizer
    import result_packetizer_pkg::*;
#(
    parameter int unsigned COORD_W = 16,
    parameter int unsigned AREA_W  = 24,
    parameter int unsigned PERIM_W = 16,
    parameter logic [7:0]  HEADER  = HEADER_DEFAULT
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               Done,
    input  logic               Error,
    input  logic [COORD_W-1:0] start_x,
    input  logic [COORD_W-1:0] start_y,
    input  logic [AREA_W-1:0]  Area,
    input  logic [PERIM_W-1:0] Perimiter,
    input  logic               Transmit_Done,
    output logic               T_EN,
    output logic [7:0]         Data,
    output logic               Busy,
    output logic               Frame_Done
);

    localparam int unsigned FRAME_LEN = frame_len(COORD_W, AREA_W, PERIM_W);
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(1);

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               overrun_q, overrun_d;
    logic               ovr_rep_q, ovr_rep_d;
    logic               err_q, err_d;
    logic [COORD_W-1:0] sx_q, sx_d;
    logic [COORD_W-1:0] sy_q, sy_d;
    logic [AREA_W-1:0]  area_q, area_d;
    logic [PERIM_W-1:0] perim_q, perim_d;
`ifdef RESULT_PACKETIZER_CHECKSUM_EN
    logic [7:0]         cks_q, cks_d;
`endif
    logic [7:0]         status;
    logic [7:0]         sel_byte;

    always_comb begin
        status          = 8'h00;
        status[ERR_BIT] = err_q;
        status[OVR_BIT] = ovr_rep_q;
    end

    result_packetizer_frame_byte_select #(
        .COORD_W (COORD_W),
        .AREA_W  (AREA_W),
        .PERIM_W (PERIM_W),
        .IDX_W   (IDX_W),
        .HEADER  (HEADER)
    ) u_byte_select (
        .idx_i      (idx_q),
        .status_i   (status),
        .start_x_i  (sx_q),
        .start_y_i  (sy_q),
        .area_i     (area_q),
        .perim_i    (perim_q),
`ifdef RESULT_PACKETIZER_CHECKSUM_EN
        .checksum_i (cks_q),
`endif
        .data_o     (sel_byte)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        ovr_rep_d = ovr_rep_q;
        err_d     = err_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        area_d    = area_q;
        perim_d   = perim_q;
`ifdef RESULT_PACKETIZER_CHECKSUM_EN
        cks_d     = cks_q;
`endif
        case (state_q)
            StIdle: begin
                if (Done) begin
                    err_d     = Error;
                    sx_d      = start_x;
                    sy_d      = start_y;
                    area_d    = Area;
                    perim_d   = Perimiter;
                    ovr_rep_d = overrun_q;
                    idx_d     = '0;
                    state_d   = StSend;
`ifdef RESULT_PACKETIZER_CHECKSUM_EN
                    cks_d     = 8'h00;
`endif
                end
            end
            StSend: state_d = StWait;
            StWait: begin
                if (Transmit_Done) begin
`ifdef RESULT_PACKETIZER_CHECKSUM_EN
                    if (idx_q != '0 && idx_q != LAST_IDX) begin
                        cks_d = cks_q ^ sel_byte;
                    end
`endif
                    // Only the overrun already reported in this STATUS byte is retired.
                    if (idx_q == STATUS_IDX) begin
                        overrun_d = overrun_q & ~ovr_rep_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = StFinish;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (Done && state_q != StIdle) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            ovr_rep_q <= 1'b0;
            err_q     <= 1'b0;
            sx_q      <= '0;
            sy_q      <= '0;
            area_q    <= '0;
            perim_q   <= '0;
`ifdef RESULT_PACKETIZER_CHECKSUM_EN
            cks_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            ovr_rep_q <= ovr_rep_d;
            err_q     <= err_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            area_q    <= area_d;
            perim_q   <= perim_d;
`ifdef RESULT_PACKETIZER_CHECKSUM_EN
            cks_q     <= cks_d;
`endif
        end
    end

    // Gating with reset keeps the strobe low even in the cycle reset is first applied.
    assign T_EN       = (state_q == StSend) && !reset;
    assign Busy       = (state_q == StSend) || (state_q == StWait);
    assign Frame_Done = (state_q == StFinish);
    assign Data       = Busy ? sel_byte : 8'h00;

endmodule

// File: tb/tb_result_packetizer.sv
// Self-checking bench for result_packetizer: byte-list reference model, UART responder,
// directed scenarios plus randomized frames with overruns.
module tb_result_packetizer;

`ifdef RESULT_PACKETIZER_CHECKSUM_EN
    localparam int FLEN = 12;
`else
    localparam int FLEN = 11;
`endif

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        Done = 1'b0;
    logic        Error = 1'b0;
    logic [15:0] start_x = '0;
    logic [15:0] start_y = '0;
    logic [23:0] Area = '0;
    logic [15:0] Perimiter = '0;
    logic        Transmit_Done = 1'b0;
    logic        T_EN;
    logic [7:0]  Data;
    logic        Busy;
    logic        Frame_Done;

    result_packetizer dut (
        .Clk           (Clk),
        .reset         (reset),
        .Done          (Done),
        .Error         (Error),
        .start_x       (start_x),
        .start_y       (start_y),
        .Area          (Area),
        .Perimiter     (Perimiter),
        .Transmit_Done (Transmit_Done),
        .T_EN          (T_EN),
        .Data          (Data),
        .Busy          (Busy),
        .Frame_Done    (Frame_Done)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: expected frame as a byte list, position, and pending overrun.
    logic [7:0] m_bytes[FLEN];
    bit m_active = 0, m_ten = 0, m_fd = 0, m_pend = 0, m_idle_now;
    int m_pos = 0;

    function automatic void build_frame(input bit err, input bit ovr, input logic [15:0] sx,
                                        input logic [15:0] sy, input logic [23:0] ar,
                                        input logic [15:0] pr);
        m_bytes[0]  = 8'hA5;
        m_bytes[1]  = {6'b0, ovr, err};
        m_bytes[2]  = sx[15:8];
        m_bytes[3]  = sx[7:0];
        m_bytes[4]  = sy[15:8];
        m_bytes[5]  = sy[7:0];
        m_bytes[6]  = ar[23:16];
        m_bytes[7]  = ar[15:8];
        m_bytes[8]  = ar[7:0];
        m_bytes[9]  = pr[15:8];
        m_bytes[10] = pr[7:0];
`ifdef RESULT_PACKETIZER_CHECKSUM_EN
        m_bytes[11] = 8'h00;
        for (int i = 1; i < 11; i++) m_bytes[11] = m_bytes[11] ^ m_bytes[i];
`endif
    endfunction

    always @(posedge Clk) begin
        if (reset) begin
            m_active = 0; m_ten = 0; m_fd = 0; m_pend = 0; m_pos = 0;
        end else begin
            m_idle_now = !m_active && !m_fd;
            if (Done && !m_idle_now) m_pend = 1;
            m_fd = 0;
            if (m_idle_now) begin
                if (Done) begin
                    build_frame(Error, m_pend, start_x, start_y, Area, Perimiter);
                    m_pend = 0; m_active = 1; m_pos = 0; m_ten = 1;
                end
            end else if (m_active) begin
                if (m_ten) m_ten = 0;
                else if (Transmit_Done) begin
                    if (m_pos == FLEN - 1) begin
                        m_active = 0; m_fd = 1;
                    end else begin
                        m_pos++; m_ten = 1;
                    end
                end
            end
        end
    end

    // Compare process plus byte capture, on the falling edge.
    logic [7:0] cap[$];
    int fd_count = 0;
    always @(negedge Clk) begin
        check("t_en", T_EN, m_ten && !reset);
        if (!reset) begin
            check("busy", Busy, m_active);
            check("frame_done", Frame_Done, m_fd);
            if (m_active) check($sformatf("data[%0d]", m_pos), Data, m_bytes[m_pos]);
        end
        if (T_EN) cap.push_back(Data);
        if (Frame_Done) fd_count++;
    end

    // UART responder: Transmit_Done ua_delay cycles after each T_EN cycle.
    int ua_delay = 10;
    int ua_cnt = 0;
    bit spur_req = 0;
    initial forever begin
        @(posedge Clk); #1;
        Transmit_Done = 1'b0;
        if (ua_cnt > 0) begin
            ua_cnt--;
            if (ua_cnt == 0) Transmit_Done = 1'b1;
        end
        if (spur_req) begin
            Transmit_Done = 1'b1;
            spur_req = 0;
        end
        if (T_EN) ua_cnt = ua_delay;
    end

    task automatic step();
        @(posedge Clk); #1;
    endtask

    task automatic scramble();
        Error = 1'($urandom_range(0, 1));
        start_x = 16'($urandom); start_y = 16'($urandom);
        Area = 24'($urandom); Perimiter = 16'($urandom);
    endtask

    task automatic pulse_done(input bit err, input logic [15:0] sx, input logic [15:0] sy,
                              input logic [23:0] ar, input logic [15:0] pr);
        Error = err; start_x = sx; start_y = sy; Area = ar; Perimiter = pr;
        Done = 1'b1;
        step();
        Done = 1'b0;
        scramble();
    endtask

    task automatic wait_cap(input int n, input string name);
        int k = 0;
        while (cap.size() < n && k < 500) begin step(); k++; end
        if (cap.size() < n) check({name, "_bytes_timeout"}, cap.size(), n);
    endtask

    task automatic wait_frame(input string name);
        int start = fd_count;
        int k = 0;
        while (fd_count == start && k < 2000) begin step(); k++; end
        check({name, "_frame_done"}, fd_count - start, 1);
    endtask

    task automatic expect_bytes(input string name, input logic [7:0] exp[$]);
        check({name, "_len"}, cap.size(), exp.size());
        for (int i = 0; i < exp.size() && i < cap.size(); i++)
            check($sformatf("%s[%0d]", name, i), cap[i], exp[i]);
    endtask

    logic [7:0] basic_q[$];
    logic [7:0] err_q[$];
    int fdc;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        basic_q = '{8'hA5, 8'h00, 8'h00, 8'h12, 8'h00, 8'h34, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40};
        err_q   = '{8'hA5, 8'h01, 8'h00, 8'h12, 8'h00, 8'h34, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40};
`ifdef RESULT_PACKETIZER_CHECKSUM_EN
        basic_q.push_back(8'h67);
        err_q.push_back(8'h66);
`endif
        // Reset state
        repeat (3) step();
        check("rst_t_en", T_EN, 0);
        check("rst_data", Data, 0);
        check("rst_busy", Busy, 0);
        check("rst_frame_done", Frame_Done, 0);
        reset = 1'b0;
        step();

        // Spurious Transmit_Done in IDLE
        spur_req = 1;
        repeat (3) step();
        check("spurious_busy", Busy, 0);
        check("spurious_bytes", cap.size(), 0);

        // Basic frame, first-byte latency
        cap.delete(); fdc = fd_count;
        pulse_done(0, 16'h0012, 16'h0034, 24'h000100, 16'h0040);
        check("latency_t_en", T_EN, 1);
        check("latency_data", Data, 8'hA5);
        wait_frame("basic");
        repeat (5) step();
        check("basic_fd_count", fd_count - fdc, 1);
        expect_bytes("basic", basic_q);

        // Error flag
        cap.delete();
        pulse_done(1, 16'h0012, 16'h0034, 24'h000100, 16'h0040);
        wait_frame("error");
        expect_bytes("error", err_q);

        // Overrun mid-frame, reported once in the next frame
        ua_delay = 5;
        cap.delete();
        pulse_done(0, 16'h0012, 16'h0034, 24'h000100, 16'h0040);
        wait_cap(4, "ovr");
        pulse_done(1, 16'hFFFF, 16'hEEEE, 24'hDDDDDD, 16'hCCCC);
        wait_frame("ovr_first");
        expect_bytes("ovr_first", basic_q);
        cap.delete();
        pulse_done(0, 16'h0012, 16'h0034, 24'h000100, 16'h0040);
        wait_frame("ovr_second");
        check("ovr_second_status", cap.size() > 1 ? cap[1] : 8'hXX, 8'h02);
        cap.delete();
        pulse_done(0, 16'h0012, 16'h0034, 24'h000100, 16'h0040);
        wait_frame("ovr_third");
        expect_bytes("ovr_third", basic_q);

        // Reset during byte 5
        ua_delay = 4;
        cap.delete();
        pulse_done(0, 16'h0012, 16'h0034, 24'h000100, 16'h0040);
        wait_cap(5, "mid_reset");
        fdc = fd_count;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_reset_t_en", T_EN, 0);
        check("mid_reset_data", Data, 0);
        check("mid_reset_busy", Busy, 0);
        check("mid_reset_frame_done", Frame_Done, 0);
        repeat (20) step();
        check("mid_reset_no_fd", fd_count - fdc, 0);
        cap.delete();
        pulse_done(0, 16'h0012, 16'h0034, 24'h000100, 16'h0040);
        wait_frame("after_reset");
        expect_bytes("after_reset", basic_q);

        // Done in the FINISH cycle is dropped, the next cycle's Done starts a frame
        ua_delay = 3;
        pulse_done(0, 16'h0012, 16'h0034, 24'h000100, 16'h0040);
        begin
            int k = 0;
            @(negedge Clk);
            while (!Frame_Done && k < 500) begin @(negedge Clk); k++; end
            check("b2b_finish_seen", Frame_Done, 1);
        end
        Done = 1'b1;
        step();
        Done = 1'b0;
        cap.delete();
        pulse_done(0, 16'h0012, 16'h0034, 24'h000100, 16'h0040);
        wait_frame("b2b");
        check("b2b_status", cap.size() > 1 ? cap[1] : 8'hXX, 8'h02);

        // Randomized frames with random UART latency and occasional overruns
        for (int f = 0; f < 40; f++) begin
            ua_delay = $urandom_range(1, 6);
            cap.delete();
            pulse_done(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                       24'($urandom), 16'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                wait_cap($urandom_range(3, FLEN), "rand_ovr");
                pulse_done(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                           24'($urandom), 16'($urandom));
            end
            wait_frame("rand");
            repeat ($urandom_range(0, 3)) step();
        end

        repeat (5) step();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
